// File: rtl/digit_stroke_pkg.sv
// Shared types and tables for the seven-segment stroke drawer.
// Build option: define DIGIT_STROKE_HEX_EN to add glyphs A,b,C,d,E,F for codes 10-15.
package digit_stroke_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    FIN  = 2'd2
  } drawState_t;

  localparam int unsigned NUM_SEGS = 7;

  localparam logic [2:0] SEG_A = 3'd0;
  localparam logic [2:0] SEG_B = 3'd1;
  localparam logic [2:0] SEG_C = 3'd2;
  localparam logic [2:0] SEG_D = 3'd3;
  localparam logic [2:0] SEG_E = 3'd4;
  localparam logic [2:0] SEG_F = 3'd5;
  localparam logic [2:0] SEG_G = 3'd6;

  // Origin expressed as multiples of the segment length L.
  typedef struct packed {
    logic [1:0] mulX;
    logic [1:0] mulY;
    logic       horiz;
  } segGeom_t;

  function automatic segGeom_t segGeom(input logic [2:0] seg);
    segGeom_t g;
    g = '{mulX: 2'd0, mulY: 2'd0, horiz: 1'b1};
    case (seg)
      SEG_A: g = '{mulX: 2'd0, mulY: 2'd0, horiz: 1'b1};
      SEG_B: g = '{mulX: 2'd1, mulY: 2'd0, horiz: 1'b0};
      SEG_C: g = '{mulX: 2'd1, mulY: 2'd1, horiz: 1'b0};
      SEG_D: g = '{mulX: 2'd0, mulY: 2'd2, horiz: 1'b1};
      SEG_E: g = '{mulX: 2'd0, mulY: 2'd1, horiz: 1'b0};
      SEG_F: g = '{mulX: 2'd0, mulY: 2'd0, horiz: 1'b0};
      SEG_G: g = '{mulX: 2'd0, mulY: 2'd1, horiz: 1'b1};
      default: g = '{mulX: 2'd0, mulY: 2'd0, horiz: 1'b1};
    endcase
    return g;
  endfunction

  // Bit n enables segment n (bit 0 = a ... bit 6 = g).
  function automatic logic [6:0] segMask(input logic [3:0] code);
    logic [6:0] m;
    m = '0;
    case (code)
      4'd0: m = 7'h3F;
      4'd1: m = 7'h06;
      4'd2: m = 7'h5B;
      4'd3: m = 7'h4F;
      4'd4: m = 7'h66;
      4'd5: m = 7'h6D;
      4'd6: m = 7'h7D;
      4'd7: m = 7'h07;
      4'd8: m = 7'h7F;
      4'd9: m = 7'h6F;
`ifdef DIGIT_STROKE_HEX_EN
      4'd10: m = 7'h77;
      4'd11: m = 7'h7C;
      4'd12: m = 7'h39;
      4'd13: m = 7'h5E;
      4'd14: m = 7'h79;
      4'd15: m = 7'h71;
`else
      default: m = '0;
`endif
    endcase
    return m;
  endfunction

  // Lowest set bit wins, which yields the a..g drawing order.
  function automatic logic [2:0] firstSeg(input logic [6:0] mask);
    logic [2:0] seg;
    logic       found;
    seg   = SEG_A;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_SEGS; i++) begin
      if (!found && mask[i]) begin
        seg   = 3'(i);
        found = 1'b1;
      end
    end
    return seg;
  endfunction

endpackage

// File: rtl/stroke_stepper.sv
// Step counter 0..SEG_LEN along one segment; advances only on an accepted pixel.
module stroke_stepper #(
  parameter int unsigned SEG_LEN = 6
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       advance,
  output logic [3:0] step,
  output logic       last
);

  localparam logic [3:0] LAST_STEP = 4'(SEG_LEN);

  assign last = (step == LAST_STEP);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      step <= '0;
    end else if (clear) begin
      step <= '0;
    end else if (advance) begin
      step <= last ? '0 : step + 4'd1;
    end
  end

endmodule

// File: rtl/digit_stroke_drawer.sv
// Draws one seven-segment glyph as a stream of pixel coordinates over a valid/ready link.
// Build option: DIGIT_STROKE_HEX_EN enables hex glyphs for codes 10-15.
module digit_stroke_drawer #(
  parameter int unsigned X_W     = 8,
  parameter int unsigned Y_W     = 7,
  parameter int unsigned SEG_LEN = 6
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic [3:0]     digit,
  input  logic [X_W-1:0] x_base,
  input  logic [Y_W-1:0] y_base,
  output logic           busy,
  output logic           pix_valid,
  input  logic           pix_ready,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic           done
);

  import digit_stroke_pkg::*;

  localparam logic [X_W-1:0] LEN_X = X_W'(SEG_LEN);
  localparam logic [Y_W-1:0] LEN_Y = Y_W'(SEG_LEN);

  drawState_t     state;
  drawState_t     stateNext;
  logic [6:0]     remMask;
  logic [6:0]     remNext;
  logic [6:0]     capMask;
  logic [2:0]     curSeg;
  logic [X_W-1:0] xBaseQ;
  logic [Y_W-1:0] yBaseQ;
  logic [3:0]     step;
  logic           last;
  logic           segDone;
  segGeom_t       geom;
  logic [X_W-1:0] offX;
  logic [Y_W-1:0] offY;

  always_comb begin
    stateNext = state;
    capMask   = segMask(digit);
    segDone   = (state == DRAW) && pix_ready && last;
    remNext   = remMask & ~(7'b1 << curSeg);
    case (state)
      IDLE: if (start) stateNext = (capMask != '0) ? DRAW : FIN;
      DRAW: if (segDone && (remNext == '0)) stateNext = FIN;
      FIN:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // The next segment is chosen on the same edge the current one finishes,
  // so disabled segments cost no cycles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      remMask <= '0;
      curSeg  <= SEG_A;
      xBaseQ  <= '0;
      yBaseQ  <= '0;
    end else if ((state == IDLE) && start) begin
      remMask <= capMask;
      curSeg  <= firstSeg(capMask);
      xBaseQ  <= x_base;
      yBaseQ  <= y_base;
    end else if (segDone) begin
      remMask <= remNext;
      curSeg  <= firstSeg(remNext);
    end
  end

  stroke_stepper #(
    .SEG_LEN (SEG_LEN)
  ) u_stepper (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (state != DRAW),
    .advance ((state == DRAW) && pix_ready),
    .step    (step),
    .last    (last)
  );

  always_comb begin
    geom = segGeom(curSeg);
    case (geom.mulX)
      2'd0:    offX = '0;
      2'd1:    offX = LEN_X;
      default: offX = LEN_X + LEN_X;
    endcase
    case (geom.mulY)
      2'd0:    offY = '0;
      2'd1:    offY = LEN_Y;
      default: offY = LEN_Y + LEN_Y;
    endcase
    x_out = xBaseQ + offX + (geom.horiz ? X_W'(step) : '0);
    y_out = yBaseQ + offY + (geom.horiz ? '0 : Y_W'(step));
  end

  assign busy      = (state == DRAW);
  assign pix_valid = (state == DRAW);
  assign done      = (state == FIN);

endmodule
